// File: rtl/btb_assoc_if.sv
// Fetch/execute/statistics bundle between the front end and the set-associative BTB.
// The DUT connects through the slave modport; the driver connects through the master modport.
interface btb_assoc_if #(
    parameter int ADDR_W = 16
);
    logic              en;
    logic              flush;
    logic [ADDR_W-1:0] pc_if;
    logic              hit_if;
    logic [ADDR_W-1:0] target_if;
    logic              stall;
    logic              br_ex;
    logic              taken_ex;
    logic [ADDR_W-1:0] pc_ex;
    logic [ADDR_W-1:0] target_ex;
    logic              hit_ex;
    logic [ADDR_W-1:0] pred_target_ex;
    logic              inc_br_cnt;
    logic              inc_hit_cnt;
    logic              inc_mispr_cnt;

    modport master (
        output en, flush, pc_if, stall, br_ex, taken_ex, pc_ex, target_ex,
               hit_ex, pred_target_ex,
        input  hit_if, target_if, inc_br_cnt, inc_hit_cnt, inc_mispr_cnt
    );

    modport slave (
        input  en, flush, pc_if, stall, br_ex, taken_ex, pc_ex, target_ex,
               hit_ex, pred_target_ex,
        output hit_if, target_if, inc_br_cnt, inc_hit_cnt, inc_mispr_cnt
    );
endinterface

// File: rtl/btb_assoc.sv
// Set-associative branch target buffer with saturating direction counters,
// combinational fetch lookup, execute-side update and registered statistics pulses.
module btb_assoc #(
    parameter int ADDR_W = 16,
    parameter int SETS   = 8,
    parameter int WAYS   = 2,
    parameter int CTR_W  = 2
) (
    input logic        clk,
    input logic        rst_n,
    btb_assoc_if.slave bus
);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDR_W - IDX_W;
    localparam int PTR_W = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam logic [CTR_W-1:0] CTR_MAX  = {CTR_W{1'b1}};
    localparam logic [CTR_W-1:0] CTR_WEAK = CTR_W'(1) << (CTR_W - 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(WAYS - 1);

    logic [WAYS-1:0]   valid_q  [SETS];
    logic [TAG_W-1:0]  tag_q    [SETS][WAYS];
    logic [ADDR_W-1:0] target_q [SETS][WAYS];
    logic [CTR_W-1:0]  ctr_q    [SETS][WAYS];
    logic [PTR_W-1:0]  ptr_q    [SETS];

    logic [IDX_W-1:0]  if_idx;
    logic [TAG_W-1:0]  if_tag;
    logic              if_match;
    logic              if_taken;
    logic [ADDR_W-1:0] if_target;

    logic [IDX_W-1:0]  ex_idx;
    logic [TAG_W-1:0]  ex_tag;
    logic              upd;
    logic              ex_match;
    logic [PTR_W-1:0]  ex_way;
    logic              free_found;
    logic [PTR_W-1:0]  free_way;
    logic [PTR_W-1:0]  alloc_way;
    logic [PTR_W-1:0]  ptr_next;
    logic [CTR_W-1:0]  ctr_cur;
    logic [CTR_W-1:0]  ctr_inc;
    logic [CTR_W-1:0]  ctr_dec;
    logic              stat_br;
    logic              stat_mispr;

    assign if_idx = bus.pc_if[IDX_W-1:0];
    assign if_tag = bus.pc_if[ADDR_W-1:IDX_W];
    assign ex_idx = bus.pc_ex[IDX_W-1:0];
    assign ex_tag = bus.pc_ex[ADDR_W-1:IDX_W];

    // Fetch lookup reads registered state only, so a same-set update is not bypassed.
    always_comb begin
        if_match  = 1'b0;
        if_taken  = 1'b0;
        if_target = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[if_idx][w] && (tag_q[if_idx][w] == if_tag)) begin
                if_match  = 1'b1;
                if_taken  = ctr_q[if_idx][w][CTR_W-1];
                if_target = target_q[if_idx][w];
            end
        end
    end

    assign bus.hit_if    = bus.en && if_match && if_taken;
    assign bus.target_if = if_target;

    always_comb begin
        ex_match   = 1'b0;
        ex_way     = '0;
        free_found = 1'b0;
        free_way   = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[ex_idx][w] && (tag_q[ex_idx][w] == ex_tag)) begin
                ex_match = 1'b1;
                ex_way   = PTR_W'(w);
            end
            if (!valid_q[ex_idx][w] && !free_found) begin
                free_found = 1'b1;
                free_way   = PTR_W'(w);
            end
        end
    end

    // Filling an empty way leaves the round-robin pointer where it is.
    assign alloc_way = free_found ? free_way : ptr_q[ex_idx];
    assign ptr_next  = (ptr_q[ex_idx] == PTR_LAST) ? '0 : ptr_q[ex_idx] + 1'b1;

    assign ctr_cur = ctr_q[ex_idx][ex_way];
    assign ctr_inc = (ctr_cur == CTR_MAX) ? ctr_cur : ctr_cur + 1'b1;
    assign ctr_dec = (ctr_cur == '0)      ? ctr_cur : ctr_cur - 1'b1;

    assign upd = bus.br_ex && !bus.stall && bus.en && !bus.flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                ptr_q[s]   <= '0;
                for (int w = 0; w < WAYS; w++) begin
                    tag_q[s][w]    <= '0;
                    target_q[s][w] <= '0;
                    ctr_q[s][w]    <= '0;
                end
            end
        end else if (bus.flush) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                ptr_q[s]   <= '0;
            end
        end else if (upd) begin
            if (ex_match) begin
                if (bus.taken_ex) begin
                    ctr_q[ex_idx][ex_way]    <= ctr_inc;
                    target_q[ex_idx][ex_way] <= bus.target_ex;
                end else begin
                    ctr_q[ex_idx][ex_way] <= ctr_dec;
                end
            end else if (bus.taken_ex) begin
                valid_q[ex_idx][alloc_way]  <= 1'b1;
                tag_q[ex_idx][alloc_way]    <= ex_tag;
                target_q[ex_idx][alloc_way] <= bus.target_ex;
                ctr_q[ex_idx][alloc_way]    <= CTR_WEAK;
                if (!free_found) begin
                    ptr_q[ex_idx] <= ptr_next;
                end
            end
        end
    end

    // Statistics ignore en and flush so a disabled predictor still yields a baseline.
    assign stat_br    = bus.br_ex && !bus.stall;
    assign stat_mispr = bus.hit_ex ? (!bus.taken_ex || (bus.pred_target_ex != bus.target_ex))
                                   : bus.taken_ex;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.inc_br_cnt    <= 1'b0;
            bus.inc_hit_cnt   <= 1'b0;
            bus.inc_mispr_cnt <= 1'b0;
        end else begin
            bus.inc_br_cnt    <= stat_br;
            bus.inc_hit_cnt   <= stat_br && bus.hit_ex;
            bus.inc_mispr_cnt <= stat_br && stat_mispr;
        end
    end
endmodule

// File: tb/tb_btb_assoc.sv
// Self-checking bench for btb_assoc: directed scenarios plus randomized traffic
// compared against a table-level reference model of the predictor.
module tb_btb_assoc;
    localparam int ADDR_W   = 16;
    localparam int SETS     = 8;
    localparam int WAYS     = 2;
    localparam int CTR_W    = 2;
    localparam int CTR_MAX  = (1 << CTR_W) - 1;
    localparam int CTR_WEAK = 1 << (CTR_W - 1);

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    btb_assoc_if #(.ADDR_W(ADDR_W)) bus ();

    btb_assoc #(
        .ADDR_W(ADDR_W),
        .SETS  (SETS),
        .WAYS  (WAYS),
        .CTR_W (CTR_W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model: each set is a small list of remembered branches.
    bit                m_valid  [SETS][WAYS];
    int                m_tag    [SETS][WAYS];
    logic [ADDR_W-1:0] m_target [SETS][WAYS];
    int                m_ctr    [SETS][WAYS];
    int                m_ptr    [SETS];
    bit                exp_br, exp_hit, exp_mispr;

    task automatic model_reset();
        for (int s = 0; s < SETS; s++) begin
            m_ptr[s] = 0;
            for (int w = 0; w < WAYS; w++) begin
                m_valid[s][w]  = 1'b0;
                m_tag[s][w]    = 0;
                m_target[s][w] = '0;
                m_ctr[s][w]    = 0;
            end
        end
        exp_br = 1'b0; exp_hit = 1'b0; exp_mispr = 1'b0;
    endtask

    function automatic void model_lookup(input logic [ADDR_W-1:0] pc, output bit hit,
                                         output logic [ADDR_W-1:0] tgt);
        int s, t;
        s = int'(pc) % SETS;
        t = int'(pc) / SETS;
        hit = 1'b0;
        tgt = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (m_valid[s][w] && m_tag[s][w] == t) begin
                tgt = m_target[s][w];
                hit = bus.en && (m_ctr[s][w] >= CTR_WEAK);
            end
        end
    endfunction

    task automatic model_edge();
        int s, t, found, victim;
        bit resolved, predicted_taken, correct;
        resolved        = bus.br_ex && !bus.stall;
        predicted_taken = bus.hit_ex;
        if (predicted_taken)
            correct = bus.taken_ex && (bus.pred_target_ex == bus.target_ex);
        else
            correct = !bus.taken_ex;
        exp_br    = resolved;
        exp_hit   = resolved && predicted_taken;
        exp_mispr = resolved && !correct;
        if (bus.flush) begin
            for (int i = 0; i < SETS; i++) begin
                m_ptr[i] = 0;
                for (int w = 0; w < WAYS; w++) m_valid[i][w] = 1'b0;
            end
        end else if (resolved && bus.en) begin
            s = int'(bus.pc_ex) % SETS;
            t = int'(bus.pc_ex) / SETS;
            found = -1;
            for (int w = 0; w < WAYS; w++)
                if (m_valid[s][w] && m_tag[s][w] == t) found = w;
            if (found >= 0) begin
                if (bus.taken_ex) begin
                    if (m_ctr[s][found] < CTR_MAX) m_ctr[s][found]++;
                    m_target[s][found] = bus.target_ex;
                end else if (m_ctr[s][found] > 0) begin
                    m_ctr[s][found]--;
                end
            end else if (bus.taken_ex) begin
                victim = -1;
                for (int w = 0; w < WAYS; w++)
                    if (!m_valid[s][w] && victim < 0) victim = w;
                if (victim < 0) begin
                    victim   = m_ptr[s];
                    m_ptr[s] = (m_ptr[s] + 1) % WAYS;
                end
                m_valid[s][victim]  = 1'b1;
                m_tag[s][victim]    = t;
                m_target[s][victim] = bus.target_ex;
                m_ctr[s][victim]    = CTR_WEAK;
            end
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.flush          = 1'b0;
        bus.stall          = 1'b0;
        bus.br_ex          = 1'b0;
        bus.taken_ex       = 1'b0;
        bus.pc_ex          = '0;
        bus.target_ex      = '0;
        bus.hit_ex         = 1'b0;
        bus.pred_target_ex = '0;
    endtask

    task automatic resolve(input logic [ADDR_W-1:0] pc, input logic [ADDR_W-1:0] tgt,
                           input bit tk);
        bit h;
        logic [ADDR_W-1:0] t;
        model_lookup(pc, h, t);
        bus.br_ex          = 1'b1;
        bus.pc_ex          = pc;
        bus.target_ex      = tgt;
        bus.taken_ex       = tk;
        bus.hit_ex         = h;
        bus.pred_target_ex = t;
        tick();
        idle();
    endtask

    task automatic do_flush();
        bus.flush = 1'b1;
        tick();
        idle();
    endtask

    task automatic test_reset();
        idle();
        model_reset();
        bus.en    = 1'b1;
        bus.pc_if = 16'h0013;
        #1;
        tests_run++;
        if (bus.hit_if !== 1'b0 || bus.target_if !== 16'h0000) begin
            tests_failed++;
            $display("[TB] FAIL reset_lookup: hit_if=%b target_if=%h, want 0/0000", bus.hit_if, bus.target_if);
        end
        tests_run++;
        if ({bus.inc_br_cnt, bus.inc_hit_cnt, bus.inc_mispr_cnt} !== 3'b000) begin
            tests_failed++;
            $display("[TB] FAIL reset_stats: br/hit/mispr=%b%b%b, want 000",
                     bus.inc_br_cnt, bus.inc_hit_cnt, bus.inc_mispr_cnt);
        end
        rst_n = 1'b1;
        bus.en             = 1'b0;
        bus.br_ex          = 1'b1;
        bus.taken_ex       = 1'b1;
        bus.pc_ex          = 16'h0021;
        bus.target_ex      = 16'h0080;
        bus.hit_ex         = 1'b0;
        tick();
        tests_run++;
        if ({bus.inc_br_cnt, bus.inc_hit_cnt, bus.inc_mispr_cnt} !== 3'b101) begin
            tests_failed++;
            $display("[TB] FAIL first_branch_stats: br/hit/mispr=%b%b%b, want 101",
                     bus.inc_br_cnt, bus.inc_hit_cnt, bus.inc_mispr_cnt);
        end
        idle();
        bus.en = 1'b1;
    endtask

    task automatic test_allocate();
        bit exp_h [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        bit steps [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        resolve(16'h0013, 16'h0040, 1'b1);
        bus.pc_if = 16'h0013;
        #1;
        tests_run++;
        if (bus.hit_if !== 1'b1 || bus.target_if !== 16'h0040) begin
            tests_failed++;
            $display("[TB] FAIL alloc_hit: hit_if=%b target_if=%h, want 1/0040", bus.hit_if, bus.target_if);
        end
        // ctr walk 2 -> 1 -> 0 -> 1 -> 2 -> 3 -> 3 (saturated)
        for (int i = 0; i < 6; i++) begin
            resolve(16'h0013, 16'h0040, steps[i]);
            bus.pc_if = 16'h0013;
            #1;
            tests_run++;
            if (bus.hit_if !== exp_h[i] || bus.target_if !== 16'h0040) begin
                tests_failed++;
                $display("[TB] FAIL ctr_step%0d: hit_if=%b target_if=%h, want %b/0040",
                         i, bus.hit_if, bus.target_if, exp_h[i]);
            end
        end
        resolve(16'h0013, 16'h0040, 1'b0);
        #1;
        tests_run++;
        if (bus.hit_if !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL ctr_saturate_dec1: hit_if=%b, want 1", bus.hit_if);
        end
        resolve(16'h0013, 16'h0040, 1'b0);
        #1;
        tests_run++;
        if (bus.hit_if !== 1'b0 || bus.target_if !== 16'h0040) begin
            tests_failed++;
            $display("[TB] FAIL ctr_saturate_dec2: hit_if=%b target_if=%h, want 0/0040",
                     bus.hit_if, bus.target_if);
        end
    endtask

    task automatic test_replacement();
        logic [ADDR_W-1:0] pcs  [4] = '{16'h0003, 16'h0013, 16'h0023, 16'h0033};
        logic [ADDR_W-1:0] tgts [4] = '{16'h0100, 16'h0200, 16'h0300, 16'h0400};
        bit hit_after3 [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        bit hit_after4 [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        do_flush();
        for (int i = 0; i < 3; i++) resolve(pcs[i], tgts[i], 1'b1);
        for (int i = 0; i < 4; i++) begin
            bus.pc_if = pcs[i];
            #1;
            tests_run++;
            if (bus.hit_if !== hit_after3[i] || bus.target_if !== (hit_after3[i] ? tgts[i] : 16'h0000)) begin
                tests_failed++;
                $display("[TB] FAIL replace3_%h: hit_if=%b target_if=%h, want hit %b",
                         pcs[i], bus.hit_if, bus.target_if, hit_after3[i]);
            end
        end
        resolve(pcs[3], tgts[3], 1'b1);
        for (int i = 0; i < 4; i++) begin
            bus.pc_if = pcs[i];
            #1;
            tests_run++;
            if (bus.hit_if !== hit_after4[i] || bus.target_if !== (hit_after4[i] ? tgts[i] : 16'h0000)) begin
                tests_failed++;
                $display("[TB] FAIL replace4_%h: hit_if=%b target_if=%h, want hit %b",
                         pcs[i], bus.hit_if, bus.target_if, hit_after4[i]);
            end
        end
    endtask

    task automatic test_target_change();
        do_flush();
        resolve(16'h0013, 16'h0040, 1'b1);
        bus.br_ex          = 1'b1;
        bus.taken_ex       = 1'b1;
        bus.pc_ex          = 16'h0013;
        bus.target_ex      = 16'h0050;
        bus.hit_ex         = 1'b1;
        bus.pred_target_ex = 16'h0040;
        tick();
        tests_run++;
        if ({bus.inc_br_cnt, bus.inc_hit_cnt, bus.inc_mispr_cnt} !== 3'b111) begin
            tests_failed++;
            $display("[TB] FAIL target_change_stats: br/hit/mispr=%b%b%b, want 111",
                     bus.inc_br_cnt, bus.inc_hit_cnt, bus.inc_mispr_cnt);
        end
        idle();
        bus.pc_if = 16'h0013;
        #1;
        tests_run++;
        if (bus.hit_if !== 1'b1 || bus.target_if !== 16'h0050) begin
            tests_failed++;
            $display("[TB] FAIL target_change_lookup: hit_if=%b target_if=%h, want 1/0050",
                     bus.hit_if, bus.target_if);
        end
    endtask

    task automatic test_flush_stall();
        bus.flush     = 1'b1;
        bus.br_ex     = 1'b1;
        bus.taken_ex  = 1'b1;
        bus.pc_ex     = 16'h0005;
        bus.target_ex = 16'h0060;
        tick();
        tests_run++;
        if (bus.inc_br_cnt !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL flush_stats: inc_br_cnt=%b, want 1", bus.inc_br_cnt);
        end
        idle();
        bus.pc_if = 16'h0005;
        #1;
        tests_run++;
        if (bus.hit_if !== 1'b0 || bus.target_if !== 16'h0000) begin
            tests_failed++;
            $display("[TB] FAIL flush_priority: hit_if=%b target_if=%h, want 0/0000", bus.hit_if, bus.target_if);
        end
        bus.pc_if = 16'h0013;
        #1;
        tests_run++;
        if (bus.hit_if !== 1'b0 || bus.target_if !== 16'h0000) begin
            tests_failed++;
            $display("[TB] FAIL flush_clears: hit_if=%b target_if=%h, want 0/0000", bus.hit_if, bus.target_if);
        end
        bus.stall          = 1'b1;
        bus.br_ex          = 1'b1;
        bus.taken_ex       = 1'b1;
        bus.pc_ex          = 16'h0007;
        bus.target_ex      = 16'h0070;
        bus.hit_ex         = 1'b1;
        bus.pred_target_ex = 16'h0070;
        tick();
        tests_run++;
        if ({bus.inc_br_cnt, bus.inc_hit_cnt, bus.inc_mispr_cnt} !== 3'b000) begin
            tests_failed++;
            $display("[TB] FAIL stall_stats: br/hit/mispr=%b%b%b, want 000",
                     bus.inc_br_cnt, bus.inc_hit_cnt, bus.inc_mispr_cnt);
        end
        bus.pc_if = 16'h0007;
        #1;
        tests_run++;
        if (bus.hit_if !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL stall_no_update: hit_if=%b, want 0", bus.hit_if);
        end
        bus.stall = 1'b0;
        tick();
        tests_run++;
        if ({bus.inc_br_cnt, bus.inc_hit_cnt, bus.inc_mispr_cnt} !== 3'b110) begin
            tests_failed++;
            $display("[TB] FAIL unstall_stats: br/hit/mispr=%b%b%b, want 110",
                     bus.inc_br_cnt, bus.inc_hit_cnt, bus.inc_mispr_cnt);
        end
        idle();
        tick();
        tests_run++;
        if (bus.inc_br_cnt !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL single_pulse: inc_br_cnt=%b, want 0", bus.inc_br_cnt);
        end
        bus.pc_if = 16'h0007;
        #1;
        tests_run++;
        if (bus.hit_if !== 1'b1 || bus.target_if !== 16'h0070) begin
            tests_failed++;
            $display("[TB] FAIL unstall_alloc: hit_if=%b target_if=%h, want 1/0070", bus.hit_if, bus.target_if);
        end
    endtask

    task automatic test_enable();
        do_flush();
        resolve(16'h0013, 16'h0040, 1'b1);
        resolve(16'h0024, 16'h0090, 1'b1);
        bus.en    = 1'b0;
        bus.pc_if = 16'h0013;
        #1;
        tests_run++;
        if (bus.hit_if !== 1'b0 || bus.target_if !== 16'h0040) begin
            tests_failed++;
            $display("[TB] FAIL disabled_lookup: hit_if=%b target_if=%h, want 0/0040", bus.hit_if, bus.target_if);
        end
        bus.br_ex     = 1'b1;
        bus.taken_ex  = 1'b1;
        bus.pc_ex     = 16'h002A;
        bus.target_ex = 16'h00A0;
        bus.hit_ex    = 1'b0;
        tick();
        tests_run++;
        if ({bus.inc_br_cnt, bus.inc_hit_cnt, bus.inc_mispr_cnt} !== 3'b101) begin
            tests_failed++;
            $display("[TB] FAIL disabled_stats: br/hit/mispr=%b%b%b, want 101",
                     bus.inc_br_cnt, bus.inc_hit_cnt, bus.inc_mispr_cnt);
        end
        idle();
        bus.en    = 1'b1;
        bus.pc_if = 16'h002A;
        #1;
        tests_run++;
        if (bus.hit_if !== 1'b0 || bus.target_if !== 16'h0000) begin
            tests_failed++;
            $display("[TB] FAIL disabled_frozen: hit_if=%b target_if=%h, want 0/0000", bus.hit_if, bus.target_if);
        end
        bus.pc_if = 16'h0024;
        #1;
        tests_run++;
        if (bus.hit_if !== 1'b1 || bus.target_if !== 16'h0090) begin
            tests_failed++;
            $display("[TB] FAIL reenable_hit: hit_if=%b target_if=%h, want 1/0090", bus.hit_if, bus.target_if);
        end
    endtask

    task automatic test_async_reset();
        resolve(16'h0013, 16'h0040, 1'b1);
        bus.br_ex     = 1'b1;
        bus.taken_ex  = 1'b1;
        bus.pc_ex     = 16'h0019;
        bus.target_ex = 16'h00B0;
        bus.pc_if     = 16'h0013;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        tests_run++;
        if (bus.hit_if !== 1'b0 || bus.target_if !== 16'h0000 || bus.inc_br_cnt !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL async_reset: hit_if=%b target_if=%h inc_br_cnt=%b, want 0/0000/0",
                     bus.hit_if, bus.target_if, bus.inc_br_cnt);
        end
        idle();
        #1;
        rst_n = 1'b1;
        tick();
        bus.pc_if = 16'h0019;
        #1;
        tests_run++;
        if (bus.hit_if !== 1'b0 || bus.inc_br_cnt !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_drops_update: hit_if=%b inc_br_cnt=%b, want 0/0",
                     bus.hit_if, bus.inc_br_cnt);
        end
    endtask

    task automatic test_random();
        bit                eh;
        logic [ADDR_W-1:0] et;
        do_flush();
        for (int i = 0; i < 1500; i++) begin
            bus.en        = ($urandom_range(0, 9) != 0);
            bus.flush     = ($urandom_range(0, 49) == 0);
            bus.stall     = ($urandom_range(0, 9) == 0);
            bus.br_ex     = ($urandom_range(0, 2) != 0);
            bus.taken_ex  = ($urandom_range(0, 2) != 0);
            bus.pc_ex     = ADDR_W'($urandom_range(0, 5) * SETS + $urandom_range(0, 3));
            bus.target_ex = ADDR_W'(16'h0400 + $urandom_range(0, 3) * 16);
            model_lookup(bus.pc_ex, eh, et);
            bus.hit_ex         = ($urandom_range(0, 7) == 0) ? !eh : eh;
            bus.pred_target_ex = et;
            bus.pc_if          = ADDR_W'($urandom_range(0, 5) * SETS + $urandom_range(0, 3));
            #1;
            model_lookup(bus.pc_if, eh, et);
            tests_run++;
            if (bus.hit_if !== eh || bus.target_if !== et) begin
                tests_failed++;
                $display("[TB] FAIL rand_lookup[%0d] pc=%h: hit_if=%b target_if=%h, want %b/%h",
                         i, bus.pc_if, bus.hit_if, bus.target_if, eh, et);
            end
            tick();
            tests_run++;
            if ({bus.inc_br_cnt, bus.inc_hit_cnt, bus.inc_mispr_cnt} !== {exp_br, exp_hit, exp_mispr}) begin
                tests_failed++;
                $display("[TB] FAIL rand_stats[%0d]: br/hit/mispr=%b%b%b, want %b%b%b", i,
                         bus.inc_br_cnt, bus.inc_hit_cnt, bus.inc_mispr_cnt, exp_br, exp_hit, exp_mispr);
            end
        end
        idle();
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit, %0d tests run, %0d failed",
                 tests_run, tests_failed);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_allocate();
        test_replacement();
        test_target_change();
        test_flush_stall();
        test_enable();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/btb_assoc.md
Name: btb_assoc

Overview:
Parametrised set-associative branch target buffer with per-entry saturating direction counters. It replaces the direct-mapped predictor in the CPU front end.
- Fetch side: combinational lookup on the pre-mux PC returns a predicted-taken hit and a target.
- Execute side: resolved branches update the tables.
- Registered single-cycle pulses feed the branch-statistics counters.

Parameters:
ADDR_W, 16, PC/target width in bits
SETS, 8, number of sets; power of 2, at least 2; IDX_W = log2(SETS)
WAYS, 2, associativity; 1..4
CTR_W, 2, direction counter width; counter MSB=1 means predict taken

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
en  in  1  prediction/update enable (SW[0])
flush  in  1  synchronous invalidate of all entries
pc_if  in  ADDR_W  fetch PC (pre-mux)
hit_if  out  1  predicted taken, fetch stage
target_if  out  ADDR_W  predicted target, fetch stage
stall  in  1  pipeline stall; suppresses update and stats
br_ex  in  1  resolving instruction is a branch/jump (EX)
taken_ex  in  1  branch actually taken (flow change)
pc_ex  in  ADDR_W  PC of resolving branch
target_ex  in  ADDR_W  actual taken target
hit_ex  in  1  hit_if pipelined to EX for this branch
pred_target_ex  in  ADDR_W  target_if pipelined to EX
inc_br_cnt  out  1  pulse: branch resolved
inc_hit_cnt  out  1  pulse: resolved branch had been predicted
inc_mispr_cnt  out  1  pulse: misprediction

Behaviour:
- Address split: index = pc[IDX_W-1:0]; tag = pc[ADDR_W-1:IDX_W]. PCs are word addresses.
- Entry fields: valid, tag, target, ctr[CTR_W-1:0].
- Per-set state: round-robin victim pointer, width max(1, log2(WAYS)).
- Reset (async, rst_n=0): all valid=0, all ctr=0, all victim pointers=0, all stat pulses=0. hit_if is therefore 0 from reset.

Lookup (combinational, zero latency):
- A way matches when valid && tag equal.
- hit_if = en && match && ctr[MSB] of the matching way.
- target_if = target of the matching way; 0 when no match.
- At most one way matches; the update rule guarantees no duplicate tags within a set.
- Lookup returns pre-update state when an update to the same set is in flight that cycle (no bypass).

Update (on posedge clk, when upd = br_ex && !stall && en && !flush):
- Match, taken_ex=1: ctr saturating increment (max 2^CTR_W-1); target <= target_ex.
- Match, taken_ex=0: ctr saturating decrement (min 0). The entry stays valid; the target is unchanged.
- No match, taken_ex=1: allocate. Victim = lowest-index invalid way; if none is invalid, victim = victim pointer and the pointer advances by 1 mod WAYS. Write valid=1, tag, target=target_ex, ctr = 2^(CTR_W-1) (weakly taken).
- No match, taken_ex=0: no change.
- Lowest-index-invalid allocation does not move the pointer.

Flush:
- Clears all valid bits and victim pointers next edge. Counters and targets are don't-care.
- flush takes priority over a same-cycle update.

Statistics (registered, 1-cycle latency; independent of en and flush):
- b = br_ex && !stall.
- inc_br_cnt <= b.
- inc_hit_cnt <= b && hit_ex.
- inc_mispr_cnt <= b && (hit_ex ? (!taken_ex || pred_target_ex != target_ex) : taken_ex).
- Each pulse is high exactly one cycle per resolved branch. A stalled EX branch counts once, on its non-stalled cycle.

en=0:
- hit_if=0; tables frozen (not updated).
- Stats continue, so every taken branch counts as a mispredict (baseline measurement).

Reset mid-operation: all state clears immediately and asynchronously; pending update is lost.

Test Plan:
- Reset then pc_if=0x0013 -> hit_if=0, target_if=0. After rst_n release, first resolved branch br_ex=1 taken_ex=1 hit_ex=0 -> inc_br_cnt=1, inc_mispr_cnt=1, inc_hit_cnt=0 one cycle later.
- Allocate: taken branch pc_ex=0x0013, target_ex=0x0040 -> next cycle pc_if=0x0013 gives hit_if=1, target_if=0x0040 (ctr=2). Two not-taken updates -> ctr=0, hit_if=0. Two taken updates -> ctr=2, hit_if=1. Further taken updates saturate at 3.
- Replacement (SETS=8, WAYS=2): taken branches at 0x0003, 0x0013, 0x0023 -> first two fill ways 0 and 1. 0x0023 evicts way 0 (pointer 0->1): lookup 0x0003 misses; 0x0013 and 0x0023 hit.
- Target change: entry 0x0013->0x0040, resolve taken to 0x0050 with hit_ex=1, pred_target_ex=0x0040 -> inc_mispr_cnt=1, inc_hit_cnt=1; next lookup target_if=0x0050.
- flush=1 coincident with a taken update to 0x0005 -> all lookups miss afterwards, including 0x0005. stall=1 with br_ex=1 -> no table change, no stat pulse.
- en=0 with populated table -> hit_if=0 for stored PCs. A taken branch -> inc_mispr_cnt=1 and the table is unchanged. Re-enable -> prior entries hit again.
